// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR round-robin arbiter.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam int                LFSR_W        = 4;
    localparam logic [LFSR_W-1:0] LFSR_TAPS_DEF = 4'b1100;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 4'b0001;

    // Widest requester vector the pick function can search.
    localparam int RR_MAX = 32;

    // Round-robin pick: first set bit of req searching upward from last+1,
    // wrapping modulo n. Returns last when nothing is requested.
    function automatic int rr_pick(input logic [RR_MAX-1:0] req,
                                   input int last,
                                   input int n);
        int   idx;
        logic found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= RR_MAX; i++) begin
            if (i <= n && !found) begin
                idx = last + i;
                if (idx >= n) idx = idx - n;
                if (req[idx[4:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR: shift left with feedback into bit 0, loadable seed with
// an all-zero guard so the register can never lock up.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEF,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_DEF
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    // Next state: load (zero replaced by SEED) beats advance; otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (load_val == '0) ? SEED : load_val;
        end else if (en) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // State register, returns to SEED on reset.
    always_ff @(posedge clk) begin
        if (RST) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin scheduler sharing one LFSR among N_REQ requesters. Each grant
// advances the LFSR STEPS times, then pulses gnt for one cycle with the word.
module lfsr_arbiter
    import lfsr_pkg::*;
#(
    parameter int               N_REQ = 4,
    parameter int               WIDTH = LFSR_W,
    parameter int               STEPS = 4,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEF,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_DEF
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    output logic [N_REQ-1:0] gnt,
    output logic [WIDTH-1:0] rnd_o,
    output logic             busy,
    output logic [WIDTH-1:0] lfsr_o
);

    localparam int OWN_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(STEPS + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] last_q,  last_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic             busy_q,  busy_d;

    logic             lfsr_en;
    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_q;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .RST      (RST),
        .en       (lfsr_en),
        .load     (lfsr_load),
        .load_val (seed_val),
        .q        (lfsr_q)
    );

    // FSM next state, LFSR controls and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        lfsr_en   = 1'b0;
        lfsr_load = 1'b0;
        case (state_q)
            IDLE: begin
                // Seed loading wins over a same-cycle request.
                if (seed_load) begin
                    lfsr_load = 1'b1;
                end else if (req != '0) begin
                    owner_d = OWN_W'(rr_pick(RR_MAX'(req), int'(last_q), N_REQ));
                    cnt_d   = '0;
                    state_d = STEP;
                end
            end
            STEP: begin
                lfsr_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STEPS - 1)) state_d = GRANT;
            end
            GRANT: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        gnt_d = '0;
        if (state_d == GRANT) gnt_d[owner_d] = 1'b1;
        busy_d = (state_d != IDLE);
    end

    // Control and output registers; reset discards any pending grant.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            last_q  <= OWN_W'(N_REQ - 1);
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign busy   = busy_q;
    assign rnd_o  = lfsr_q;
    assign lfsr_o = lfsr_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Scoreboard bench for lfsr_arbiter with default parameters.
module tb_lfsr_arbiter;

    logic       clk = 1'b0;
    logic       RST;
    logic [3:0] req;
    logic       seed_load;
    logic [3:0] seed_val;
    logic [3:0] gnt;
    logic [3:0] rnd_o;
    logic       busy;
    logic [3:0] lfsr_o;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] rnd;
        int         cyc;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   next_id = 0;

    lfsr_arbiter dut (
        .clk       (clk),
        .RST       (RST),
        .req       (req),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt),
        .rnd_o     (rnd_o),
        .busy      (busy),
        .lfsr_o    (lfsr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [3:0] r, input int c);
        exp_t e;
        e.gnt = g;
        e.rnd = r;
        e.cyc = c;
        e.id  = next_id;
        next_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: every grant pulse is matched against the next expected entry.
    always @(negedge clk) begin
        if (gnt !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_grant: got gnt=%b rnd=%b, expected no grant (cycle %0d)", gnt, rnd_o, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                tests++;
                if (gnt !== e.gnt) begin
                    fails++;
                    $display("FAIL grant%0d_gnt: got %b, expected %b", e.id, gnt, e.gnt);
                end
                tests++;
                if (rnd_o !== e.rnd) begin
                    fails++;
                    $display("FAIL grant%0d_rnd: got %b, expected %b", e.id, rnd_o, e.rnd);
                end
                tests++;
                if (cyc != e.cyc) begin
                    fails++;
                    $display("FAIL grant%0d_cycle: got %0d, expected %0d", e.id, cyc, e.cyc);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        RST = 1'b1;
        req = 4'b0000;
        seed_load = 1'b0;
        seed_val = 4'b0000;
        repeat (2) @(negedge clk);
        RST = 1'b0;
    endtask

    task automatic wait_grants(input int n);
        int seen = 0;
        int t = 0;
        while (seen < n && t < 200) begin
            @(negedge clk);
            t++;
            if (gnt !== 4'b0000) seen++;
        end
        if (seen < n) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: got %0d grants, expected %0d", seen, n);
        end
    endtask

    initial begin
        int k;
        RST = 1'b1;
        req = 4'b0000;
        seed_load = 1'b0;
        seed_val = 4'b0000;

        // 1. Reset values, then reset in the middle of STEP.
        do_reset();
        check4("reset_lfsr", lfsr_o, 4'b0001);
        check4("reset_rnd", rnd_o, 4'b0001);
        check4("reset_gnt", gnt, 4'b0000);
        check4("reset_busy", {3'b000, busy}, 4'b0000);
        req = 4'b0001;
        @(negedge clk);
        check4("step_busy", {3'b000, busy}, 4'b0001);
        @(negedge clk);
        check4("step_lfsr", lfsr_o, 4'b0010);
        RST = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        RST = 1'b0;
        check4("midstep_rst_busy", {3'b000, busy}, 4'b0000);
        check4("midstep_rst_lfsr", lfsr_o, 4'b0001);
        repeat (8) @(negedge clk);

        // 2. Single requester, two grants.
        do_reset();
        k = cyc;
        push(4'b0001, 4'b0011, k + 5);
        push(4'b0001, 4'b0101, k + 11);
        req = 4'b0001;
        wait_grants(2);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check4("single_idle_busy", {3'b000, busy}, 4'b0000);

        // 3. Round-robin between requesters 0 and 1.
        do_reset();
        k = cyc;
        push(4'b0001, 4'b0011, k + 5);
        push(4'b0010, 4'b0101, k + 11);
        push(4'b0001, 4'b1110, k + 17);
        push(4'b0010, 4'b0010, k + 23);
        req = 4'b0011;
        wait_grants(4);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // 4. Seed load, then zero-seed guard.
        do_reset();
        seed_load = 1'b1;
        seed_val = 4'b1001;
        @(negedge clk);
        seed_load = 1'b0;
        check4("seed_loaded", lfsr_o, 4'b1001);
        k = cyc;
        push(4'b0100, 4'b1010, k + 5);
        req = 4'b0100;
        wait_grants(1);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        seed_load = 1'b1;
        seed_val = 4'b0000;
        @(negedge clk);
        seed_load = 1'b0;
        check4("zero_seed_guard", lfsr_o, 4'b0001);

        // 5a. Seed load during STEP is ignored (request also dropped early).
        do_reset();
        k = cyc;
        push(4'b0001, 4'b0011, k + 5);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        seed_load = 1'b1;
        seed_val = 4'b1000;
        @(negedge clk);
        seed_load = 1'b0;
        wait_grants(1);
        repeat (2) @(negedge clk);

        // 5b. Seed load and request in the same IDLE cycle.
        k = cyc;
        push(4'b0010, 4'b1011, k + 6);
        seed_load = 1'b1;
        seed_val = 4'b0110;
        req = 4'b0010;
        @(negedge clk);
        seed_load = 1'b0;
        check4("seed_vs_req_lfsr", lfsr_o, 4'b0110);
        check4("seed_vs_req_busy", {3'b000, busy}, 4'b0000);
        wait_grants(1);
        req = 4'b0000;
        repeat (2) @(negedge clk);

        // 6. One-cycle request is still granted.
        k = cyc;
        push(4'b0100, 4'b1100, k + 5);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        wait_grants(1);
        repeat (2) @(negedge clk);
        check4("drop_idle_busy", {3'b000, busy}, 4'b0000);

        repeat (4) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_grants: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation ran past %0d cycles, expected completion", cyc);
        $fatal(1);
    end

endmodule
